// File: rtl/lstm_seq_feeder.sv
// lstm_seq_feeder: packs a byte-wide stream of syscall IDs into 64-bit words,
// queues them in a small FIFO and steps the LSTM core once per word using the
// lstm_enable/lstm_done handshake. Each resulting hidden state is forwarded
// downstream as a one-cycle h_valid pulse tagged with end-of-sequence.
// Optional feature: define LSTM_FEEDER_WDOG_EN to enable the step watchdog
// (TIMEOUT cycles, sticky wdog_err).
module lstm_seq_feeder #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_id,
   input  logic        in_last,
   output logic        lstm_enable,
   output logic        lstm_init,
   output logic [63:0] syscall_X_data,
   input  logic        lstm_done,
   input  logic [63:0] syscall_H_out,
   output logic        h_valid,
   output logic [63:0] h_data,
   output logic        h_last,
   output logic        wdog_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_LOW,
      S_WAIT_HIGH,
      S_CAPTURE
   } state_t;

   // Input handshake: an ID transfers on a rising clk edge where
   // in_valid && in_ready. in_ready depends only on FIFO occupancy, so it
   // stays low for the whole cycle while the FIFO is full, even if the FSM
   // pops in that same cycle.

   // Packer state
   logic [2:0]  idx_q, idx_d;
   logic [63:0] pack_q, pack_d;
   logic [63:0] pack_word;
   logic        accept;
   logic        close;

   // FIFO state (bit 64 of each entry is the end-of-sequence flag)
   logic [64:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [64:0]   push_word;
   logic [64:0]   head_word;

   // Sequencer state and registered outputs
   state_t      state_q;
   logic        enable_q;
   logic        init_q;
   logic        first_q;
   logic        cur_last_q;
   logic [63:0] x_data_q;
   logic        h_valid_q;
   logic [63:0] h_data_q;
   logic        h_last_q;

   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign in_ready   = !fifo_full;
   assign head_word  = fifo_mem[rd_ptr_q];
   assign pop        = (state_q == S_IDLE) && !fifo_empty;

   // Packer: drop the accepted ID into its byte lane and close the word on the
   // 8th ID or on in_last; a closed word leaves the upper bytes at zero.
   always_comb begin
      accept    = in_valid && in_ready;
      close     = accept && (in_last || (idx_q == 3'd7));
      pack_word = pack_q;
      pack_word[{idx_q, 3'b000} +: 8] = in_id;
      push      = close;
      push_word = {in_last, pack_word};
      idx_d     = idx_q;
      pack_d    = pack_q;
      if (close) begin
         idx_d  = 3'd0;
         pack_d = '0;
      end else if (accept) begin
         idx_d  = idx_q + 3'd1;
         pack_d = pack_word;
      end
   end

   // Packer registers: index and partially filled word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= 3'd0;
         pack_q <= '0;
      end else begin
         idx_q  <= idx_d;
         pack_q <= pack_d;
      end
   end

   // FIFO storage: written on every closed word
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= push_word;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave count as is
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef LSTM_FEEDER_WDOG_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] wdog_cnt_q;
   logic          wdog_q;
   assign wdog_err = wdog_q;
`else
   // Watchdog compiled out: the flag is a constant 0 (TIMEOUT is never negative).
   assign wdog_err = (TIMEOUT < 0);
`endif

   // Step sequencer: the word is loaded and lstm_enable raised on the edge that
   // enters ISSUE, so the core sees them during the ISSUE cycle; the hidden
   // state is captured on the edge leaving CAPTURE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         enable_q   <= 1'b0;
         init_q     <= 1'b0;
         first_q    <= 1'b1;
         cur_last_q <= 1'b0;
         x_data_q   <= '0;
         h_valid_q  <= 1'b0;
         h_data_q   <= '0;
         h_last_q   <= 1'b0;
`ifdef LSTM_FEEDER_WDOG_EN
         wdog_cnt_q <= '0;
         wdog_q     <= 1'b0;
`endif
      end else begin
         enable_q  <= 1'b0;
         init_q    <= 1'b0;
         h_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  x_data_q   <= head_word[63:0];
                  cur_last_q <= head_word[64];
                  enable_q   <= 1'b1;
                  init_q     <= first_q;
                  first_q    <= head_word[64];
                  state_q    <= S_ISSUE;
`ifdef LSTM_FEEDER_WDOG_EN
                  wdog_cnt_q <= '0;
`endif
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
               if (!lstm_done) state_q <= S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
               if (lstm_done) state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               h_data_q  <= syscall_H_out;
               h_last_q  <= cur_last_q;
               h_valid_q <= 1'b1;
               state_q   <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
`ifdef LSTM_FEEDER_WDOG_EN
         // Abandon a step whose core never answers; restart the sequence.
         if ((state_q == S_ISSUE) || (state_q == S_WAIT_LOW) || (state_q == S_WAIT_HIGH)) begin
            wdog_cnt_q <= wdog_cnt_q + WW'(1);
            if ((state_q != S_ISSUE) && (wdog_cnt_q >= WW'(TIMEOUT - 1))) begin
               wdog_q  <= 1'b1;
               first_q <= 1'b1;
               state_q <= S_IDLE;
            end
         end
`endif
      end
   end

   assign lstm_enable    = enable_q;
   assign lstm_init      = init_q;
   assign syscall_X_data = x_data_q;
   assign h_valid        = h_valid_q;
   assign h_data         = h_data_q;
   assign h_last         = h_last_q;

endmodule
